// File: rtl/fabric_config_loader_if.sv
// Serial configuration bus for fabric_config_loader.
//   cfg_start : one-cycle pulse that begins or restarts a load
//   cfg_bit   : serial data bit
//   cfg_valid : cfg_bit is valid
//   cfg_ready : loader accepts a bit this cycle
interface fabric_config_loader_if;
  logic cfg_start;
  logic cfg_bit;
  logic cfg_valid;
  logic cfg_ready;

  modport master (output cfg_start, output cfg_bit, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_start, input cfg_bit, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/fabric_config_loader.sv
// Serial configuration controller for the programmable fabric.
// Shifts a bitstream into shadow registers, verifies an 8-bit XOR-fold
// trailer, and only on a match commits the shadow into the active tile and
// switch-box configuration. A failed or aborted load leaves the active
// configuration untouched.
//   clock     : rising-edge clock
//   reset_n   : synchronous active-low reset
//   cfg       : serial bus (start / bit / valid / ready)
//   tile_cfg  : active tile config, tile t at [t*TILE_BITS +: TILE_BITS]
//   sw_cfg    : active switch config, switch s at [s*SWITCH_BITS +: SWITCH_BITS]
//   busy      : high in LOAD, CHECK and COMMIT
//   cfg_done  : one-cycle pulse after commit
//   cfg_error : checksum mismatch, held until next cfg_start or reset
module fabric_config_loader #(
  parameter int NUM_TILES    = 4,
  parameter int NUM_SWITCHES = 4,
  parameter int TILE_BITS    = 33,
  parameter int SWITCH_BITS  = 16
) (
  input  logic                              clock,
  input  logic                              reset_n,
  fabric_config_loader_if.slave             cfg,
  output logic [NUM_TILES*TILE_BITS-1:0]    tile_cfg,
  output logic [NUM_SWITCHES*SWITCH_BITS-1:0] sw_cfg,
  output logic                              busy,
  output logic                              cfg_done,
  output logic                              cfg_error
);

  localparam int TILE_TOTAL = NUM_TILES * TILE_BITS;
  localparam int TOTAL_BITS = TILE_TOTAL + NUM_SWITCHES * SWITCH_BITS;
  localparam int CW         = $clog2(TOTAL_BITS + 1);

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, COMMIT, ERROR} state_t;

  state_t                state, state_n;
  logic [CW-1:0]         cnt;
  logic [7:0]            chk;
  logic                  mism;
  logic [TOTAL_BITS-1:0] shadow;

  logic beat;
  logic restart;
  logic load_last;
  logic trailer_last;
  logic bit_mism;

  assign cfg.cfg_ready = (state == LOAD) || (state == CHECK);
  assign busy          = (state == LOAD) || (state == CHECK) || (state == COMMIT);

  always_comb begin
    beat         = cfg.cfg_valid && cfg.cfg_ready;
    // A start pulse during COMMIT is ignored so the commit always completes.
    restart      = cfg.cfg_start && (state != COMMIT);
    load_last    = (cnt == CW'(TOTAL_BITS - 1));
    trailer_last = (cnt == CW'(7));
    bit_mism     = cfg.cfg_bit ^ chk[cnt[2:0]];
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (restart) state_n = LOAD;
      LOAD: begin
        if (restart)                state_n = LOAD;
        else if (beat && load_last) state_n = CHECK;
      end
      CHECK: begin
        if (restart)                   state_n = LOAD;
        else if (beat && trailer_last) state_n = (mism || bit_mism) ? ERROR : COMMIT;
      end
      COMMIT: state_n = IDLE;
      ERROR:  if (restart) state_n = LOAD;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      chk       <= '0;
      mism      <= 1'b0;
      tile_cfg  <= '0;
      sw_cfg    <= '0;
      cfg_done  <= 1'b0;
      cfg_error <= 1'b0;
    end else begin
      state     <= state_n;
      cfg_done  <= (state == COMMIT);
      cfg_error <= (state_n == ERROR);
      if (restart) begin
        // A beat coincident with the start pulse is dropped.
        cnt  <= '0;
        chk  <= '0;
        mism <= 1'b0;
      end else begin
        unique case (state)
          LOAD: if (beat) begin
            chk[cnt[2:0]] <= chk[cnt[2:0]] ^ cfg.cfg_bit;
            cnt           <= load_last ? '0 : cnt + CW'(1);
          end
          CHECK: if (beat) begin
            mism <= mism || bit_mism;
            cnt  <= trailer_last ? '0 : cnt + CW'(1);
          end
          COMMIT: begin
            tile_cfg <= shadow[TILE_TOTAL-1:0];
            sw_cfg   <= shadow[TOTAL_BITS-1:TILE_TOTAL];
          end
          default: ;
        endcase
      end
    end
  end

  // Shadow registers carry no reset; their contents only matter after a
  // complete, checksum-verified load.
  always_ff @(posedge clock) begin
    if (state == LOAD && beat && !restart)
      shadow[cnt] <= cfg.cfg_bit;
  end

endmodule

// File: tb/tb_fabric_config_loader.sv
module tb_fabric_config_loader;

  localparam int TB_BITS = 196;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [131:0] tile_cfg;
  logic [63:0]  sw_cfg;
  logic         busy, cfg_done, cfg_error;

  int passed = 0;
  int total  = 0;
  int done_cnt = 0;

  fabric_config_loader_if bus ();

  fabric_config_loader #(
    .NUM_TILES(4), .NUM_SWITCHES(4), .TILE_BITS(33), .SWITCH_BITS(16)
  ) dut (
    .clock(clock), .reset_n(reset_n), .cfg(bus),
    .tile_cfg(tile_cfg), .sw_cfg(sw_cfg),
    .busy(busy), .cfg_done(cfg_done), .cfg_error(cfg_error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (reset_n === 1'b1 && cfg_done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] fold(input logic [TB_BITS-1:0] p);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < TB_BITS; k++) r[k % 8] = r[k % 8] ^ p[k];
    return r;
  endfunction

  task automatic start_pulse();
    bus.cfg_start = 1'b1;
    @(negedge clock);
    bus.cfg_start = 1'b0;
  endtask

  task automatic send_stream(input logic [TB_BITS-1:0] p, input logic [7:0] tr, input bit gapped);
    logic b;
    for (int k = 0; k < TB_BITS + 8; k++) begin
      b = (k < TB_BITS) ? p[k] : tr[k - TB_BITS];
      bus.cfg_bit   = b;
      bus.cfg_valid = 1'b1;
      @(negedge clock);
      if (gapped && k != TB_BITS + 7) begin
        bus.cfg_valid = 1'b0;
        @(negedge clock);
      end
    end
    bus.cfg_valid = 1'b0;
  endtask

  logic [TB_BITS-1:0] good_pat, sw_pat;
  logic [131:0]       tile_good;
  logic [63:0]        sw_good;
  int                 d0, wait_cyc;
  time                t0, t1;

  initial begin
    good_pat = '0;
    good_pat[32:0] = '1;
    sw_pat = '0;
    sw_pat[132 +: 16] = 16'h8421;
    tile_good = '0;
    tile_good[32:0] = 33'h1_FFFF_FFFF;
    sw_good = '0;
    sw_good[15:0] = 16'h8421;

    // Reset with random inputs
    reset_n = 1'b0;
    bus.cfg_start = 1'b0; bus.cfg_bit = 1'b0; bus.cfg_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.cfg_start = 1'($urandom_range(0, 1));
      bus.cfg_bit   = 1'($urandom_range(0, 1));
      bus.cfg_valid = 1'($urandom_range(0, 1));
      @(negedge clock);
    end
    check("rst_tile", tile_cfg, 0);
    check("rst_sw", sw_cfg, 0);
    check("rst_ready", bus.cfg_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", cfg_done, 0);
    check("rst_error", cfg_error, 0);
    bus.cfg_start = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_bit = 1'b0;
    reset_n = 1'b1;
    @(negedge clock);

    // Good load
    start_pulse();
    check("start_ready", bus.cfg_ready, 1);
    check("start_busy", busy, 1);
    d0 = done_cnt;
    send_stream(good_pat, 8'h01, 1'b0);
    check("commit_busy", busy, 1);
    check("commit_done_early", cfg_done, 0);
    check("commit_tile_old", tile_cfg, 0);
    @(negedge clock);
    check("good_done", cfg_done, 1);
    check("good_tile", tile_cfg, tile_good);
    check("good_sw", sw_cfg, 0);
    check("good_busy", busy, 0);
    @(negedge clock);
    check("good_done_fall", cfg_done, 0);
    check("good_done_count", done_cnt - d0, 1);

    // Bad checksum
    start_pulse();
    d0 = done_cnt;
    send_stream(good_pat, 8'h00, 1'b0);
    check("bad_error", cfg_error, 1);
    check("bad_busy", busy, 0);
    check("bad_ready", bus.cfg_ready, 0);
    repeat (3) @(negedge clock);
    check("bad_error_held", cfg_error, 1);
    check("bad_tile_kept", tile_cfg, tile_good);
    check("bad_sw_kept", sw_cfg, 0);
    check("bad_no_done", done_cnt - d0, 0);
    start_pulse();
    check("bad_error_clear", cfg_error, 0);
    check("bad_restart_busy", busy, 1);

    // Gapped valid (load already started above)
    t0 = $time;
    d0 = done_cnt;
    send_stream(good_pat, 8'h01, 1'b1);
    wait_cyc = 0;
    while (cfg_done !== 1'b1 && wait_cyc < 20) begin
      @(negedge clock);
      wait_cyc++;
    end
    t1 = $time;
    check("gap_latency", (t1 - t0) / 10, 408);
    check("gap_tile", tile_cfg, tile_good);
    check("gap_sw", sw_cfg, 0);
    @(negedge clock);
    check("gap_done_count", done_cnt - d0, 1);

    // Restart mid-load, with a beat coincident with the second start
    start_pulse();
    for (int k = 0; k < 50; k++) begin
      bus.cfg_bit = 1'b1; bus.cfg_valid = 1'b1;
      @(negedge clock);
    end
    bus.cfg_start = 1'b1; bus.cfg_bit = 1'b1; bus.cfg_valid = 1'b1;
    @(negedge clock);
    bus.cfg_start = 1'b0; bus.cfg_valid = 1'b0;
    d0 = done_cnt;
    send_stream(sw_pat, fold(sw_pat), 1'b0);
    @(negedge clock);
    check("rs_done", cfg_done, 1);
    check("rs_sw", sw_cfg, sw_good);
    check("rs_tile", tile_cfg, 0);
    check("rs_error", cfg_error, 0);
    @(negedge clock);

    // Reset mid-load
    start_pulse();
    for (int k = 0; k < 100; k++) begin
      bus.cfg_bit = 1'b1; bus.cfg_valid = 1'b1;
      @(negedge clock);
    end
    bus.cfg_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    check("mr_tile", tile_cfg, 0);
    check("mr_sw", sw_cfg, 0);
    check("mr_busy", busy, 0);
    bus.cfg_bit = 1'b1; bus.cfg_valid = 1'b1;
    repeat (5) @(negedge clock);
    check("mr_ready", bus.cfg_ready, 0);
    check("mr_idle_busy", busy, 0);
    check("mr_error", cfg_error, 0);
    bus.cfg_valid = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
